fp_norm_shift: RTL and testbench
================================

// Module: fp_norm_shift
// PURPOSE
//  Normalization stage that consumes the leading-one position from the LOPD tree.
//  Takes a raw add/sub mantissa, its leading-one index and zero flag, then left-shifts
//  until the leading one reaches the MSB, and subtracts the shift from the exponent.
//  Two-stage pipeline with valid/ready handshake on both sides, between LOPD and rounding.
// PARAMETERS
//  MANT_W  24                 mantissa width incl. hidden bit; MSB is the normalized position
//  EXP_W   8                  biased exponent width
//  POS_W   $clog2(MANT_W)     width of leading-one index (5 for default)
// PORTS
//  i_clk        in   1       clock, all logic on rising edge
//  i_rst        in   1       synchronous reset, active-high
//  i_valid      in   1       upstream beat valid
//  o_ready      out  1       block can accept a beat this cycle
//  i_mant       in   MANT_W  un-normalized mantissa
//  i_pos_one    in   POS_W   bit index (from LSB) of leading one in i_mant
//  i_zero_flag  in   1       i_mant is all zero
//  i_exp        in   EXP_W   biased exponent before normalization
//  i_sign       in   1       sign, passed through
//  o_valid      out  1       output beat valid
//  i_ready      in   1       downstream accepts beat
//  o_mant       out  MANT_W  normalized mantissa
//  o_exp        out  EXP_W   adjusted exponent
//  o_sign       out  1       sign passthrough
//  o_zero       out  1       result is exact zero
//  o_denorm     out  1       result is subnormal (exponent clamped to 0)
// BEHAVIOUR
//  - Reset: o_valid=0, o_mant=0, o_exp=0, o_sign=0, o_zero=0, o_denorm=0; in-flight beats dropped.
//  - Reset mid-operation: both stage valids cleared at next edge; no partial beat emerges.
//  - Handshake: beat transfers on i_valid&o_ready (in) and o_valid&i_ready (out).
//    o_valid/o_* held stable while o_valid&~i_ready. Each stage loads when empty or draining.
//    o_ready = ~s1_valid | (~s2_valid | i_ready). Combinational i_ready->o_ready path is allowed.
//  - Latency: exactly 2 cycles accept-to-o_valid with no stall; throughput 1 beat/cycle.
//  - Shift amount: shamt = (MANT_W-1) - pos, pos = min(i_pos_one, MANT_W-1).
//  - Normal case (i_exp > shamt): shift left by shamt, o_exp = i_exp - shamt, o_denorm=0.
//  - Subnormal case (i_exp <= shamt, i_zero_flag=0): shift = (i_exp==0) ? 0 : i_exp-1;
//    o_exp=0, o_denorm=1. Leading one does not reach MSB.
//  - Zero case (i_zero_flag=1): o_mant=0, o_exp=0, o_zero=1, o_denorm=0, sign kept;
//    i_pos_one and i_exp ignored.
//  - Stage 1 (on accept): compute effective shift, exponent, flags; shift mantissa by
//    shift & ~7 (coarse, multiples of 8); register all with s1_valid.
//  - Stage 2: shift by shift[2:0] (fine), register to outputs with s2_valid (=o_valid).
//  - Shift fills zeros at LSB; bits shifted out of MSB cannot occur (shift <= shamt).
//  - Exponent arithmetic unsigned EXP_W bits; no wrap possible given the case split.
// TESTING (MANT_W=24, EXP_W=8)
//  1. mant=0x000100 pos=8 exp=100 -> 2 cycles later o_mant=0x800000 o_exp=85 denorm=0.
//  2. mant=0x800001 pos=23 exp=1 -> o_mant=0x800001 o_exp=1, no shift, flags 0.
//  3. mant=0x000010 pos=4 exp=10 -> shift 9: o_mant=0x002000 o_exp=0 o_denorm=1.
//  4. zero_flag=1 sign=1 mant=0 exp=77 -> o_mant=0 o_exp=0 o_zero=1 o_sign=1.
//  5. 4 back-to-back beats, i_ready=0 for 3 cycles -> o_ready low after 2 held beats;
//     outputs stable while stalled; all 4 delivered in order, none lost or duplicated.
//  6. i_rst asserted with 2 beats in flight -> next cycle o_valid=0, all outputs 0; new
//     beat after reset emerges 2 cycles after accept.

Source files
------------

// File: rtl/fp_norm_shift.sv
// Two-stage normalization shifter: moves the leading one of a raw add/sub mantissa to
// the MSB (coarse byte shift, then fine bit shift) and adjusts the exponent accordingly.
module fp_norm_shift #(
  parameter int MANT_W = 24,
  parameter int EXP_W  = 8,
  parameter int POS_W  = $clog2(MANT_W)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [MANT_W-1:0] i_mant,
  input  logic [POS_W-1:0]  i_pos_one,
  input  logic              i_zero_flag,
  input  logic [EXP_W-1:0]  i_exp,
  input  logic              i_sign,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [MANT_W-1:0] o_mant,
  output logic [EXP_W-1:0]  o_exp,
  output logic              o_sign,
  output logic              o_zero,
  output logic              o_denorm
);

  localparam int CW = ((EXP_W > POS_W) ? EXP_W : POS_W) + 1;
  localparam logic [POS_W-1:0] TOP_POS = POS_W'(MANT_W - 1);

  logic              s2_load_s;
  logic              s1_load_s;
  logic [POS_W-1:0]  pos_s;
  logic [POS_W-1:0]  shamt_s;
  logic [POS_W-1:0]  shift_s;
  logic [POS_W-1:0]  coarse_amt_s;
  logic [CW-1:0]     exp_ext_s;
  logic [CW-1:0]     shamt_ext_s;
  logic [EXP_W-1:0]  exp_s;
  logic              zero_s;
  logic              denorm_s;
  logic [MANT_W-1:0] coarse_s;

  logic              s1_valid_r;
  logic [MANT_W-1:0] s1_mant_r;
  logic [2:0]        s1_fine_r;
  logic [EXP_W-1:0]  s1_exp_r;
  logic              s1_sign_r;
  logic              s1_zero_r;
  logic              s1_denorm_r;

  // Pipeline advance: a stage loads when it is empty or its content leaves this cycle.
  always_comb begin
    s2_load_s = ~o_valid | i_ready;
    s1_load_s = ~s1_valid_r | s2_load_s;
    o_ready   = s1_load_s;
  end

  // Stage-1 decode: effective shift, adjusted exponent, flags and the coarse shift.
  always_comb begin
    pos_s       = (i_pos_one > TOP_POS) ? TOP_POS : i_pos_one;
    shamt_s     = TOP_POS - pos_s;
    exp_ext_s   = CW'(i_exp);
    shamt_ext_s = CW'(shamt_s);
    shift_s     = {POS_W{1'b0}};
    exp_s       = {EXP_W{1'b0}};
    zero_s      = 1'b0;
    denorm_s    = 1'b0;
    if (i_zero_flag) begin
      zero_s = 1'b1;
    end else if (exp_ext_s > shamt_ext_s) begin
      shift_s = shamt_s;
      exp_s   = i_exp - EXP_W'(shamt_s);
    end else begin
      // Exponent too small to absorb the full shift: stop at exponent 1, encode as 0.
      denorm_s = 1'b1;
      if (i_exp == {EXP_W{1'b0}}) begin
        shift_s = {POS_W{1'b0}};
      end else begin
        shift_s = POS_W'(i_exp - 1'b1);
      end
    end
    coarse_amt_s = {shift_s[POS_W-1:3], 3'b000};
    if (i_zero_flag) begin
      coarse_s = {MANT_W{1'b0}};
    end else begin
      coarse_s = i_mant << coarse_amt_s;
    end
  end

  // Stage-1 register: captures the coarsely shifted beat on accept.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_valid_r  <= 1'b0;
      s1_mant_r   <= {MANT_W{1'b0}};
      s1_fine_r   <= 3'b000;
      s1_exp_r    <= {EXP_W{1'b0}};
      s1_sign_r   <= 1'b0;
      s1_zero_r   <= 1'b0;
      s1_denorm_r <= 1'b0;
    end else if (s1_load_s) begin
      s1_valid_r <= i_valid;
      if (i_valid) begin
        s1_mant_r   <= coarse_s;
        s1_fine_r   <= shift_s[2:0];
        s1_exp_r    <= exp_s;
        s1_sign_r   <= i_sign;
        s1_zero_r   <= zero_s;
        s1_denorm_r <= denorm_s;
      end
    end
  end

  // Stage-2 register: fine shift into the held output beat.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid  <= 1'b0;
      o_mant   <= {MANT_W{1'b0}};
      o_exp    <= {EXP_W{1'b0}};
      o_sign   <= 1'b0;
      o_zero   <= 1'b0;
      o_denorm <= 1'b0;
    end else if (s2_load_s) begin
      o_valid <= s1_valid_r;
      if (s1_valid_r) begin
        o_mant   <= s1_mant_r << s1_fine_r;
        o_exp    <= s1_exp_r;
        o_sign   <= s1_sign_r;
        o_zero   <= s1_zero_r;
        o_denorm <= s1_denorm_r;
      end
    end
  end

endmodule

// File: tb/tb_fp_norm_shift.sv
// Randomized bench for fp_norm_shift: a reference model built from the normalization
// rules predicts every output beat, its earliest arrival cycle and the ready level.
module tb_fp_norm_shift;

  typedef struct {
    logic [23:0] mant;
    logic [7:0]  exp;
    logic        sign;
    logic        zero;
    logic        denorm;
    int          acc;
  } res_t;

  logic        i_clk;
  logic        i_rst;
  logic        i_valid;
  logic        o_ready;
  logic [23:0] i_mant;
  logic [4:0]  i_pos_one;
  logic        i_zero_flag;
  logic [7:0]  i_exp;
  logic        i_sign;
  logic        o_valid;
  logic        i_ready;
  logic [23:0] o_mant;
  logic [7:0]  o_exp;
  logic        o_sign;
  logic        o_zero;
  logic        o_denorm;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_del = -100;
  bit   head_seen = 1'b0;
  bit   rst_seen = 1'b0;
  bit   hold_v = 1'b0;
  res_t hold_r;
  res_t exp_q[$];
  int   stall_cnt = 0;
  bit   rand_rdy = 1'b0;

  fp_norm_shift dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_mant(i_mant), .i_pos_one(i_pos_one), .i_zero_flag(i_zero_flag),
    .i_exp(i_exp), .i_sign(i_sign), .o_valid(o_valid), .i_ready(i_ready),
    .o_mant(o_mant), .o_exp(o_exp), .o_sign(o_sign), .o_zero(o_zero),
    .o_denorm(o_denorm)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Normalization rules in plain integer arithmetic.
  function automatic res_t model(input logic [23:0] m, input int pos, input bit z, input int e, input bit s);
    res_t r;
    int   p;
    int   sh;
    int   sub;
    r.sign = s; r.zero = 1'b0; r.denorm = 1'b0; r.acc = 0;
    p  = (pos > 23) ? 23 : pos;
    sh = 23 - p;
    if (z) begin
      r.mant = 24'h000000; r.exp = 8'h00; r.zero = 1'b1;
    end else if (e > sh) begin
      r.mant = m << sh; r.exp = 8'(e - sh);
    end else begin
      sub = (e == 0) ? 0 : e - 1;
      r.mant = m << sub; r.exp = 8'h00; r.denorm = 1'b1;
    end
    return r;
  endfunction

  function automatic logic [63:0] pack(input res_t r);
    return {29'd0, r.mant, r.exp, r.sign, r.zero, r.denorm};
  endfunction

  // Single compare process, sampling between active edges.
  always @(negedge i_clk) begin
    res_t cur;
    res_t h;
    int   first;
    cyc++;
    cur.mant = o_mant; cur.exp = o_exp; cur.sign = o_sign;
    cur.zero = o_zero; cur.denorm = o_denorm; cur.acc = 0;
    if (rst_seen) begin
      chk(!o_valid && pack(cur) == 64'd0, "reset_outputs", {o_valid, pack(cur)[62:0]}, 64'd0);
    end
    if (i_rst) begin
      exp_q.delete();
      head_seen = 1'b0;
      last_del  = -100;
      hold_v    = 1'b0;
      rst_seen  = 1'b1;
    end else begin
      rst_seen = 1'b0;
      if (hold_v) begin
        chk(o_valid && pack(cur) == pack(hold_r), "hold_stable", pack(cur), pack(hold_r));
      end
      chk(o_ready == (i_ready || exp_q.size() < 2), "o_ready", 64'(o_ready),
          64'(i_ready || exp_q.size() < 2));
      if (o_valid) begin
        if (exp_q.size() == 0) begin
          chk(1'b0, "spurious_valid", 64'd1, 64'd0);
        end else begin
          h = exp_q[0];
          if (!head_seen) begin
            first = (h.acc + 2 > last_del + 1) ? h.acc + 2 : last_del + 1;
            chk(cyc == first, "latency", 64'(cyc - h.acc), 64'(first - h.acc));
            head_seen = 1'b1;
          end
          if (i_ready) begin
            chk(pack(cur) == pack(h), "beat_data", pack(cur), pack(h));
            void'(exp_q.pop_front());
            last_del  = cyc;
            head_seen = 1'b0;
          end
        end
      end
      hold_v = o_valid && !i_ready;
      hold_r = cur;
      if (i_valid && o_ready) begin
        h = model(i_mant, int'(i_pos_one), i_zero_flag, int'(i_exp), i_sign);
        h.acc = cyc;
        exp_q.push_back(h);
      end
    end
  end

  task automatic step();
    @(posedge i_clk);
    #1;
    if (stall_cnt > 0) begin
      i_ready = 1'b0;
      stall_cnt--;
    end else if (rand_rdy) begin
      i_ready = ($urandom_range(0, 3) != 0);
    end else begin
      i_ready = 1'b1;
    end
  endtask

  task automatic drive(input logic [23:0] m, input logic [4:0] p, input logic z,
                       input logic [7:0] e, input logic s);
    bit ok;
    i_mant = m; i_pos_one = p; i_zero_flag = z; i_exp = e; i_sign = s;
    i_valid = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge i_clk);
      ok = o_ready;
      step();
    end
    if (!ok) chk(1'b0, "accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic idle(input int n);
    i_valid = 1'b0;
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    res_t        r;
    logic [23:0] m;
    logic [31:0] rnd;
    int          p;
    int          k;
    i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1; i_mant = 24'h0;
    i_pos_one = 5'd0; i_zero_flag = 1'b0; i_exp = 8'd0; i_sign = 1'b0;

    r = model(24'h000100, 8, 1'b0, 100, 1'b0);
    chk(r.mant == 24'h800000 && r.exp == 8'd85 && !r.denorm, "pin_normal", pack(r), 64'h0);
    r = model(24'h800001, 23, 1'b0, 1, 1'b0);
    chk(r.mant == 24'h800001 && r.exp == 8'd1 && !r.denorm && !r.zero, "pin_noshift", pack(r), 64'h0);
    r = model(24'h000010, 4, 1'b0, 10, 1'b0);
    chk(r.mant == 24'h002000 && r.exp == 8'd0 && r.denorm, "pin_subnormal", pack(r), 64'h0);
    r = model(24'h000000, 0, 1'b1, 77, 1'b1);
    chk(r.mant == 24'h0 && r.exp == 8'd0 && r.zero && r.sign && !r.denorm, "pin_zero", pack(r), 64'h0);

    step(); step(); step();
    i_rst = 1'b0;
    step();

    drive(24'h000100, 5'd8, 1'b0, 8'd100, 1'b0);  idle(4);
    drive(24'h800001, 5'd23, 1'b0, 8'd1, 1'b0);   idle(4);
    drive(24'h000010, 5'd4, 1'b0, 8'd10, 1'b0);   idle(4);
    drive(24'h000000, 5'd0, 1'b1, 8'd77, 1'b1);   idle(4);
    drive(24'h000001, 5'd0, 1'b0, 8'd0, 1'b1);    idle(4);
    drive(24'h800000, 5'd31, 1'b0, 8'd200, 1'b0); idle(4);

    // Four back-to-back beats against a three-cycle downstream stall.
    i_ready = 1'b0; stall_cnt = 2;
    drive(24'h000100, 5'd8, 1'b0, 8'd100, 1'b0);
    drive(24'h00F000, 5'd15, 1'b0, 8'd50, 1'b1);
    drive(24'h000003, 5'd1, 1'b0, 8'd5, 1'b0);
    drive(24'h400000, 5'd22, 1'b0, 8'd2, 1'b1);
    idle(6);

    // Reset with two beats in flight, then one fresh beat.
    i_ready = 1'b0; stall_cnt = 40;
    drive(24'h001234, 5'd12, 1'b0, 8'd90, 1'b1);
    drive(24'h0000FF, 5'd7, 1'b0, 8'd60, 1'b0);
    idle(1);
    i_rst = 1'b1;
    step();
    i_rst = 1'b0; stall_cnt = 0; i_ready = 1'b1;
    step();
    drive(24'h000100, 5'd8, 1'b0, 8'd100, 1'b0);
    idle(5);

    rand_rdy = 1'b1;
    for (int b = 0; b < 400; b++) begin
      rnd = $urandom;
      p = $urandom_range(0, 23);
      m = (24'h1 << p) | (rnd[23:0] & ((24'h1 << p) - 24'h1));
      k = $urandom_range(0, 9);
      if ($urandom_range(0, 3) == 0) idle(1);
      if (k == 0) begin
        drive(24'h0, 5'($urandom_range(0, 31)), 1'b1, 8'($urandom_range(0, 255)), 1'($urandom));
      end else if (k == 1) begin
        drive(m | 24'h800000, 5'($urandom_range(24, 31)), 1'b0, 8'($urandom_range(0, 255)), 1'($urandom));
      end else if (k < 6) begin
        drive(m, 5'(p), 1'b0, 8'($urandom_range(0, 30)), 1'($urandom));
      end else begin
        drive(m, 5'(p), 1'b0, 8'($urandom_range(0, 255)), 1'($urandom));
      end
    end
    rand_rdy = 1'b0;
    idle(10);
    chk(exp_q.size() == 0, "drain", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
